// File: rtl/csr_file_if.sv
// Bus between the core controller and the machine-mode CSR file:
// CSR access, interrupt lines, retire/trap/mret strobes and the
// trap-target outputs.
interface csr_file_if #(
    parameter int XLEN = 32
);
    logic            csr_en;
    logic [1:0]      op;
    logic [11:0]     adr;
    logic [XLEN-1:0] din;
    logic [XLEN-1:0] dout;
    logic            illegal;
    logic            irq_ext;
    logic            irq_sw;
    logic            irq_timer;
    logic            instret;
    logic            trap;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_val;
    logic            mret;
    logic            irq_take;
    logic [XLEN-1:0] irq_cause;
    logic [XLEN-1:0] trap_vector;
    logic [XLEN-1:0] epc;

    modport master (
        output csr_en, op, adr, din, irq_ext, irq_sw, irq_timer, instret,
               trap, trap_cause, trap_pc, trap_val, mret,
        input  dout, illegal, irq_take, irq_cause, trap_vector, epc
    );

    modport slave (
        input  csr_en, op, adr, din, irq_ext, irq_sw, irq_timer, instret,
               trap, trap_cause, trap_pc, trap_val, mret,
        output dout, illegal, irq_take, irq_cause, trap_vector, epc
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus, misa, mie, mtvec, mscratch, mepc, mcause,
// mtval, mip, mhartid. Produces the interrupt request/cause and the trap
// target. Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters
// and their user-mode read-only aliases.
module csr_file #(
    parameter int              XLEN        = 32,
    parameter logic [31:0]     MISA_VAL    = 32'h4000_0100,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] HART_ID     = '0
) (
    input logic       clk,
    input logic       rst,
    csr_file_if.slave bus
);
    localparam logic [XLEN-1:0] MSTATUS_MPP = XLEN'(32'h1800);
    localparam logic [XLEN-1:0] MIE_MASK    = XLEN'(32'h888);

    logic            st_mie;
    logic            st_mpie;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;

    logic [XLEN-1:0] mstatus_v;
    logic [XLEN-1:0] mip_v;
    logic [XLEN-1:0] pend;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] vec_base;
    logic            impl;
    logic            read_only;
    logic            csr_we;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;
    logic [63:0] mcycle_d;
    logic [63:0] minstret_d;
`endif

    // Assemble the composite views: mstatus with fixed MPP, live mip.
    always_comb begin
        mstatus_v     = MSTATUS_MPP;
        mstatus_v[3]  = st_mie;
        mstatus_v[7]  = st_mpie;
        mip_v         = '0;
        mip_v[3]      = bus.irq_sw;
        mip_v[7]      = bus.irq_timer;
        mip_v[11]     = bus.irq_ext;
    end

    // Address decode: read data, implemented and read-only flags.
    always_comb begin
        rdata     = '0;
        impl      = 1'b1;
        read_only = 1'b0;
        case (bus.adr)
            12'h300: rdata = mstatus_v;
            12'h301: begin rdata = XLEN'(MISA_VAL); read_only = 1'b1; end
            12'h304: rdata = mie_q;
            12'h305: rdata = mtvec_q;
            12'h340: rdata = mscratch_q;
            12'h341: rdata = mepc_q;
            12'h342: rdata = mcause_q;
            12'h343: rdata = mtval_q;
            12'h344: begin rdata = mip_v; read_only = 1'b1; end
            12'hF14: rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: rdata = mcycle_q[XLEN-1:0];
            12'hB02, 12'hC02: rdata = minstret_q[XLEN-1:0];
            12'hB80, 12'hC80: begin
                if (XLEN == 32) rdata = XLEN'(mcycle_q[63:32]);
                else            impl  = 1'b0;
            end
            12'hB82, 12'hC82: begin
                if (XLEN == 32) rdata = XLEN'(minstret_q[63:32]);
                else            impl  = 1'b0;
            end
`endif
            default: impl = 1'b0;
        endcase
    end

    // Access legality, read port and write-operand formation.
    always_comb begin
        bus.illegal = bus.csr_en &&
                      (!impl || (bus.op != 2'b00 && (read_only || bus.adr[11:10] == 2'b11)));
        bus.dout    = bus.csr_en ? rdata : '0;
        csr_we      = bus.csr_en && !bus.illegal && bus.op != 2'b00 && !bus.trap && !bus.mret;
        case (bus.op)
            2'b10:   wdata = rdata | bus.din;
            2'b11:   wdata = rdata & ~bus.din;
            default: wdata = bus.din;
        endcase
    end

    // Interrupt arbitration (ext > sw > timer) and trap target.
    always_comb begin
        pend         = mip_v & mie_q;
        bus.irq_take = st_mie && (pend != '0);
        bus.irq_cause = '0;
        if (pend[11])     bus.irq_cause = XLEN'(11);
        else if (pend[3]) bus.irq_cause = XLEN'(3);
        else if (pend[7]) bus.irq_cause = XLEN'(7);
        if (pend != '0) bus.irq_cause[XLEN-1] = 1'b1;
        vec_base = {mtvec_q[XLEN-1:2], 2'b00};
        if (bus.trap_cause[XLEN-1] && mtvec_q[1:0] == 2'b01)
            bus.trap_vector = vec_base + {bus.trap_cause[XLEN-3:0], 2'b00};
        else
            bus.trap_vector = vec_base;
        bus.epc = mepc_q;
    end

    // CSR state: reset > trap > mret > CSR write.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (bus.trap) begin
            mepc_q   <= {bus.trap_pc[XLEN-1:2], 2'b00};
            mcause_q <= bus.trap_cause;
            mtval_q  <= bus.trap_val;
            st_mpie  <= st_mie;
            st_mie   <= 1'b0;
        end else if (bus.mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (csr_we) begin
            case (bus.adr)
                12'h300: begin
                    st_mie  <= wdata[3];
                    st_mpie <= wdata[7];
                end
                12'h304: mie_q <= wdata & MIE_MASK;
                12'h305: begin
                    mtvec_q[XLEN-1:2] <= wdata[XLEN-1:2];
                    // MODE is WARL: only 0/1 are accepted, 2/3 keep the old mode
                    if (!wdata[1]) mtvec_q[1:0] <= wdata[1:0];
                end
                12'h340: mscratch_q <= wdata;
                12'h341: mepc_q     <= {wdata[XLEN-1:2], 2'b00};
                12'h342: mcause_q   <= wdata;
                12'h343: mtval_q    <= wdata;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    // Counter next-state: free-running increment, a CSR write overrides it.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, bus.instret};
        if (csr_we) begin
            case (bus.adr)
                12'hB00: mcycle_d   = (XLEN == 32) ? {mcycle_q[63:32], wdata[31:0]} : 64'(wdata);
                12'hB02: minstret_d = (XLEN == 32) ? {minstret_q[63:32], wdata[31:0]} : 64'(wdata);
                12'hB80: mcycle_d   = {wdata[31:0], mcycle_q[31:0]};
                12'hB82: minstret_d = {wdata[31:0], minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`endif
endmodule
